// File: rtl/stream_unpacker_pkg.sv
// Shared types, default widths and sizing helpers for the stream unpacker
// and the dump-file bench stages that surround it.
package tb_stream_pkg;

   // Width of one record word as it comes out of dump.bin.
   localparam int DUMP_WIDTH = 48;

   // Width of one lane on the narrow-datapath side.
   localparam int LANE_WIDTH = 16;

   // EMPTY: no word held. SHIFT: a word is held and beats are being emitted.
   typedef enum logic {
      EMPTY,
      SHIFT
   } unpack_state_e;

   // Number of output beats needed to carry one input word (ceiling division).
   function automatic int beats_for(input int in_w, input int out_w);
      return (in_w + out_w - 1) / out_w;
   endfunction

   // Width of a beat index; never narrower than one bit so a single-beat
   // configuration still has a real out_idx port.
   function automatic int idx_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/stream_unpacker_if.sv
// Handshake bundle for the stream unpacker: a wide word-in side and a
// narrow beat-out side. The slave modport is the unpacker's view, the
// master modport is the view of whatever surrounds it (file reader + sink).
interface stream_unpacker_if
   import tb_stream_pkg::*;
#(
   parameter int IN_WIDTH  = DUMP_WIDTH,
   parameter int OUT_WIDTH = LANE_WIDTH
);

   localparam int BEATS = beats_for(IN_WIDTH, OUT_WIDTH);
   localparam int IDX_W = idx_width(BEATS);

   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_last;

   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_last;
   logic [IDX_W-1:0]     out_idx;
   logic                 busy;

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      output in_ready,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_last,
      output out_idx,
      output busy
   );

   modport master (
      output in_valid,
      output in_data,
      output in_last,
      input  in_ready,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_last,
      input  out_idx,
      input  busy
   );

endinterface

// File: rtl/stream_unpacker.sv
// Serialises each IN_WIDTH-bit word into OUT_WIDTH-bit beats, LSB first,
// carrying the frame-end flag onto the final beat of the word. A new word
// can be taken on the same edge the final beat leaves, so a steady stream
// runs at one beat per cycle with no bubbles between words.
module stream_unpacker
   import tb_stream_pkg::*;
#(
   parameter int IN_WIDTH  = DUMP_WIDTH,
   parameter int OUT_WIDTH = LANE_WIDTH
) (
   input logic             clk,
   input logic             rst,
   stream_unpacker_if.slave bus
);

   localparam int BEATS  = beats_for(IN_WIDTH, OUT_WIDTH);
   localparam int IDX_W  = idx_width(BEATS);
   localparam int HELD_W = BEATS * OUT_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   unpack_state_e     state_q, state_d;
   logic [HELD_W-1:0] held_q, held_d;
   logic              held_last_q, held_last_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   logic out_valid_w;
   logic beat_xfer;
   logic final_xfer;
   logic in_ready_w;
   logic accept;

   // Handshake decode: a beat leaves on valid&&ready, and the slot frees up
   // either when idle or as the final beat of the held word is taken.
   always_comb begin
      out_valid_w = (state_q == SHIFT);
      beat_xfer   = out_valid_w && bus.out_ready;
      final_xfer  = beat_xfer && (idx_q == LAST_IDX);
      in_ready_w  = !rst && ((state_q == EMPTY) || final_xfer);
      accept      = bus.in_valid && in_ready_w;
   end

   // Next-state logic: a fresh accept wins over draining, so a final-beat
   // transfer and a new word on the same edge keeps the unpacker in SHIFT.
   always_comb begin
      state_d     = state_q;
      held_d      = held_q;
      held_last_d = held_last_q;
      idx_d       = idx_q;
      if (accept) begin
         held_d                 = '0;
         held_d[IN_WIDTH-1:0]   = bus.in_data;
         held_last_d            = bus.in_last;
         idx_d                  = '0;
         state_d                = SHIFT;
      end else if (final_xfer) begin
         held_d      = '0;
         held_last_d = 1'b0;
         idx_d       = '0;
         state_d     = EMPTY;
      end else if (beat_xfer) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   // State, holding register and beat counter; reset drops any held word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         held_q      <= '0;
         held_last_q <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         held_q      <= held_d;
         held_last_q <= held_last_d;
         idx_q       <= idx_d;
      end
   end

   // Outputs come straight from registered state; only in_ready looks at
   // out_ready, which is what lets words run back to back.
   always_comb begin
      bus.in_ready  = in_ready_w;
      bus.out_valid = out_valid_w;
      bus.busy      = out_valid_w;
      bus.out_idx   = idx_q;
      bus.out_data  = held_q[int'(idx_q) * OUT_WIDTH +: OUT_WIDTH];
      bus.out_last  = out_valid_w && held_last_q && (idx_q == LAST_IDX);
   end

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: a 48/16 instance for the main
// behaviour and a 40/16 instance for the zero-padded final beat.
module tb_stream_unpacker;
   import tb_stream_pkg::*;

   typedef struct {
      logic [15:0] data;
      int          idx;
      logic        last;
      int          cyc;
   } beat_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;

   beat_t q48[$];
   beat_t q40[$];

   stream_unpacker_if #(.IN_WIDTH(48), .OUT_WIDTH(16)) u_if ();
   stream_unpacker_if #(.IN_WIDTH(40), .OUT_WIDTH(16)) u_if40 ();

   stream_unpacker #(.IN_WIDTH(48), .OUT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   stream_unpacker #(.IN_WIDTH(40), .OUT_WIDTH(16)) dut40 (
      .clk (clk),
      .rst (rst),
      .bus (u_if40.slave)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to check that beats land on consecutive cycles.
   always @(posedge clk) cyc <= cyc + 1;

   // Beat collectors, sampled mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (!rst && u_if.out_valid && u_if.out_ready)
         q48.push_back('{data: u_if.out_data, idx: int'(u_if.out_idx), last: u_if.out_last, cyc: cyc});
      if (!rst && u_if40.out_valid && u_if40.out_ready)
         q40.push_back('{data: u_if40.out_data, idx: int'(u_if40.out_idx), last: u_if40.out_last, cyc: cyc});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_cmp++;
      if (observed !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Present one word to the 48-bit instance and hold it until accepted.
   task automatic applyStimulus(input logic [47:0] data, input logic last);
      int n;
      n = 0;
      u_if.in_valid = 1'b1;
      u_if.in_data  = data;
      u_if.in_last  = last;
      #1;
      while (!u_if.in_ready && n < 20) begin
         tick();
         n++;
      end
      checkOutput("accept_wait", 64'(n < 20), 64'd1);
      tick();
      u_if.in_valid = 1'b0;
   endtask

   logic [15:0] exp3 [3];
   int          w;
   int          n_acc;
   logic        took;
   int          n_last;

   initial begin
      cyc   = 0;
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      u_if.in_valid   = 1'b0;
      u_if.in_data    = '0;
      u_if.in_last    = 1'b0;
      u_if.out_ready  = 1'b1;
      u_if40.in_valid  = 1'b0;
      u_if40.in_data   = '0;
      u_if40.in_last   = 1'b0;
      u_if40.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      checkOutput("rst_in_ready", 64'(u_if.in_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("rst_out_valid", 64'(u_if.out_valid), 64'd0);
      checkOutput("rst_out_last", 64'(u_if.out_last), 64'd0);
      checkOutput("rst_out_idx", 64'(u_if.out_idx), 64'd0);
      checkOutput("rst_out_data", 64'(u_if.out_data), 64'd0);
      checkOutput("rst_busy", 64'(u_if.busy), 64'd0);
      checkOutput("rst_in_ready_after", 64'(u_if.in_ready), 64'd1);

      // Test 1: single word, out_ready=1
      exp3 = '{16'h9ABC, 16'h5678, 16'h1234};
      applyStimulus(48'h1234_5678_9ABC, 1'b1);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("t1_valid%0d", k), 64'(u_if.out_valid), 64'd1);
         checkOutput($sformatf("t1_data%0d", k), 64'(u_if.out_data), 64'(exp3[k]));
         checkOutput($sformatf("t1_idx%0d", k), 64'(u_if.out_idx), 64'(k));
         checkOutput($sformatf("t1_last%0d", k), 64'(u_if.out_last), 64'(k == 2));
         tick();
      end
      checkOutput("t1_idle", 64'(u_if.out_valid), 64'd0);

      // Test 2: four words back to back
      q48.delete();
      n_acc = 0;
      w = 1;
      u_if.in_valid = 1'b1;
      u_if.in_last  = 1'b0;
      for (int c = 0; c < 40 && w <= 4; c++) begin
         u_if.in_data = 48'(w);
         #1;
         took = u_if.in_ready;
         if (took) n_acc++;
         tick();
         if (took) w++;
      end
      u_if.in_valid = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      checkOutput("t2_accepts", 64'(n_acc), 64'd4);
      checkOutput("t2_beats", 64'(q48.size()), 64'd12);
      if (q48.size() == 12) begin
         checkOutput("t2_span", 64'(q48[11].cyc - q48[0].cyc), 64'd11);
         for (int j = 0; j < 12; j++)
            checkOutput($sformatf("t2_data%0d", j), 64'(q48[j].data), (j % 3 == 0) ? 64'(j / 3 + 1) : 64'd0);
      end

      // Test 3: backpressure on beat 1
      q48.delete();
      applyStimulus(48'hAAAA_BBBB_CCCC, 1'b0);
      checkOutput("t3_beat0", 64'(u_if.out_data), 64'hCCCC);
      tick();
      u_if.out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         checkOutput($sformatf("t3_stall_data%0d", s), 64'(u_if.out_data), 64'hBBBB);
         checkOutput($sformatf("t3_stall_idx%0d", s), 64'(u_if.out_idx), 64'd1);
         checkOutput($sformatf("t3_stall_valid%0d", s), 64'(u_if.out_valid), 64'd1);
         checkOutput($sformatf("t3_stall_in_ready%0d", s), 64'(u_if.in_ready), 64'd0);
         tick();
      end
      u_if.out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      checkOutput("t3_beats", 64'(q48.size()), 64'd3);
      if (q48.size() == 3) begin
         checkOutput("t3_q0", 64'(q48[0].data), 64'hCCCC);
         checkOutput("t3_q1", 64'(q48[1].data), 64'hBBBB);
         checkOutput("t3_q2", 64'(q48[2].data), 64'hAAAA);
      end

      // Test 4: 40-bit word, zero-padded final beat
      q40.delete();
      u_if40.in_valid = 1'b1;
      u_if40.in_data  = 40'hAA_BBCC_DDEE;
      u_if40.in_last  = 1'b1;
      #1;
      checkOutput("t4_in_ready", 64'(u_if40.in_ready), 64'd1);
      tick();
      u_if40.in_valid = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      checkOutput("t4_beats", 64'(q40.size()), 64'd3);
      if (q40.size() == 3) begin
         checkOutput("t4_q0", 64'(q40[0].data), 64'hDDEE);
         checkOutput("t4_q1", 64'(q40[1].data), 64'hBBCC);
         checkOutput("t4_q2", 64'(q40[2].data), 64'h00AA);
         checkOutput("t4_idx2", 64'(q40[2].idx), 64'd2);
         checkOutput("t4_last2", 64'(q40[2].last), 64'd1);
      end

      // Test 5: reset in the middle of a word
      q48.delete();
      applyStimulus(48'h1111_2222_3333, 1'b0);
      checkOutput("t5_beat0", 64'(u_if.out_data), 64'h3333);
      tick();
      rst = 1'b1;
      #1;
      checkOutput("t5_in_ready_rst", 64'(u_if.in_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("t5_valid", 64'(u_if.out_valid), 64'd0);
      checkOutput("t5_idx", 64'(u_if.out_idx), 64'd0);
      tick();
      applyStimulus(48'h4444_5555_6666, 1'b0);
      checkOutput("t5_new_beat0", 64'(u_if.out_data), 64'h6666);
      for (int c = 0; c < 4; c++) tick();
      checkOutput("t5_beats", 64'(q48.size()), 64'd4);
      if (q48.size() == 4) begin
         checkOutput("t5_q0", 64'(q48[0].data), 64'h3333);
         checkOutput("t5_q1", 64'(q48[1].data), 64'h6666);
         checkOutput("t5_q3", 64'(q48[3].data), 64'h4444);
      end

      // Test 6: frame flag only on the last beat of the last word
      q48.delete();
      n_acc = 0;
      w = 1;
      u_if.in_valid = 1'b1;
      for (int c = 0; c < 40 && w <= 3; c++) begin
         u_if.in_data = 48'(w);
         u_if.in_last = (w == 3);
         #1;
         took = u_if.in_ready;
         tick();
         if (took) w++;
      end
      u_if.in_valid = 1'b0;
      u_if.in_last  = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      checkOutput("t6_beats", 64'(q48.size()), 64'd9);
      n_last = 0;
      foreach (q48[j]) if (q48[j].last) n_last++;
      checkOutput("t6_last_count", 64'(n_last), 64'd1);
      if (q48.size() == 9) begin
         checkOutput("t6_last_pos", 64'(q48[8].last), 64'd1);
         checkOutput("t6_last_idx", 64'(q48[8].idx), 64'd2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
